// File: rtl/skolem_sweep_pkg.sv
// Shared types and constants for the Skolem-netlist sweep controller.
package skolem_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

  localparam int MAX_LAT = 4;

  // The failure counter must reach 2^num_in without wrapping.
  function automatic int cnt_width(input int num_in);
    return num_in + 1;
  endfunction

endpackage

// File: rtl/skolem_sweep_ctrl_if.sv
// Host/netlist-facing bundle of the sweep controller; slave = controller side.
interface skolem_sweep_ctrl_if #(
  parameter int NUM_IN = 8
);
  import skolem_sweep_pkg::*;

  logic                         start;
  logic                         abort;
  logic                         spec_ok;
  logic [NUM_IN-1:0]            vec_out;
  logic                         vec_valid;
  logic                         busy;
  logic                         done;
  logic                         pass;
  logic [cnt_width(NUM_IN)-1:0] fail_cnt;
  logic [NUM_IN-1:0]            first_fail;

  modport master (
    output start, abort, spec_ok,
    input  vec_out, vec_valid, busy, done, pass, fail_cnt, first_fail
  );

  modport slave (
    input  start, abort, spec_ok,
    output vec_out, vec_valid, busy, done, pass, fail_cnt, first_fail
  );

endinterface

// File: rtl/skolem_sweep_tagpipe.sv
// LAT-deep {valid, vector} delay line aligning issued vectors with checker verdicts.
module skolem_sweep_tagpipe
  import skolem_sweep_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int LAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              vld_i,
  input  logic [NUM_IN-1:0] vec_i,
  output logic              vld_o,
  output logic [NUM_IN-1:0] vec_o
);

  if (LAT == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = clk ^ rst ^ flush_i;
    assign vld_o     = vld_i;
    assign vec_o     = vec_i;
  end else begin : g_pipe
    logic [LAT-1:0]             vld_q;
    logic [LAT-1:0][NUM_IN-1:0] vec_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        vec_q <= '0;
      end else begin
        vld_q[0] <= vld_i && !flush_i;
        vec_q[0] <= vec_i;
        for (int i = 1; i < LAT; i++) begin
          vld_q[i] <= vld_q[i-1] && !flush_i;
          vec_q[i] <= vec_q[i-1];
        end
      end
    end

    assign vld_o = vld_q[LAT-1];
    assign vec_o = vec_q[LAT-1];
  end

endmodule

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep of all 2^NUM_IN inputs of a Skolem netlist, tallying checker failures.
// Optional build macro SKOLEM_SWEEP_STOP_ON_FAIL_EN: stop issuing vectors at the first failure.
module skolem_sweep_ctrl
  import skolem_sweep_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int LAT    = 0
) (
  input  logic                clk,
  input  logic                rst,
  skolem_sweep_ctrl_if.slave  sw
);

  localparam int                CW         = cnt_width(NUM_IN);
  localparam int                DW         = $clog2(MAX_LAT + 1);
  localparam logic [NUM_IN-1:0] VEC_MAX    = {NUM_IN{1'b1}};
  localparam logic [CW-1:0]     CNT_MAX    = {1'b1, {NUM_IN{1'b0}}};
  localparam logic [DW-1:0]     DRAIN_LAST = DW'((LAT > 0) ? LAT - 1 : 0);

  sweep_state_e      state_q;
  logic [NUM_IN-1:0] vec_q;
  logic              vld_q, busy_q, done_q, pass_q;
  logic [CW-1:0]     fail_cnt_q, fail_cnt_d;
  logic [NUM_IN-1:0] first_fail_q, first_fail_d;
  logic [DW-1:0]     drain_q;
  logic              tag_vld, tag_fail, abort_act, stop_issue;
  logic [NUM_IN-1:0] tag_vec;

  assign abort_act = sw.abort && (state_q == SWEEP || state_q == DRAIN);

  skolem_sweep_tagpipe #(
    .NUM_IN (NUM_IN),
    .LAT    (LAT)
  ) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .flush_i (abort_act),
    .vld_i   (vld_q),
    .vec_i   (vec_q),
    .vld_o   (tag_vld),
    .vec_o   (tag_vec)
  );

  // A response arriving on the abort edge is dropped along with the pipeline.
  assign tag_fail = tag_vld && !sw.spec_ok && !abort_act;

`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
  assign stop_issue = tag_fail;
`else
  assign stop_issue = 1'b0;
`endif

  always_comb begin
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    if (tag_fail) begin
      if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
      if (fail_cnt_q == '0)      first_fail_d = tag_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      vld_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      drain_q      <= '0;
    end else begin
      done_q       <= 1'b0;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      case (state_q)
        IDLE: begin
          if (sw.start && !sw.abort) begin
            state_q      <= SWEEP;
            vec_q        <= '0;
            vld_q        <= 1'b1;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
          end
        end
        SWEEP: begin
          if (abort_act) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (vec_q == VEC_MAX || stop_issue) begin
            vld_q <= 1'b0;
            if (LAT > 0) begin
              state_q <= DRAIN;
              drain_q <= DRAIN_LAST;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_cnt_d == '0);
            end
          end else begin
            vec_q <= vec_q + 1'b1;
          end
        end
        DRAIN: begin
          if (abort_act) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (drain_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_cnt_d == '0);
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sw.vec_out    = vec_q;
  assign sw.vec_valid  = vld_q;
  assign sw.busy       = busy_q;
  assign sw.done       = done_q;
  assign sw.pass       = pass_q;
  assign sw.fail_cnt   = fail_cnt_q;
  assign sw.first_fail = first_fail_q;

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Directed bench: three controllers (LAT 0/1/2, NUM_IN=8) driven by small checker models.
module tb_skolem_sweep_ctrl;
  import skolem_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  skolem_sweep_ctrl_if #(.NUM_IN(8)) if0 ();
  skolem_sweep_ctrl_if #(.NUM_IN(8)) if1 ();
  skolem_sweep_ctrl_if #(.NUM_IN(8)) if2 ();

  skolem_sweep_ctrl #(.NUM_IN(8), .LAT(0)) u0 (.clk(clk), .rst(rst), .sw(if0));
  skolem_sweep_ctrl #(.NUM_IN(8), .LAT(1)) u1 (.clk(clk), .rst(rst), .sw(if1));
  skolem_sweep_ctrl #(.NUM_IN(8), .LAT(2)) u2 (.clk(clk), .rst(rst), .sw(if2));

  logic start_r [3];
  logic abort_r [3];
  assign if0.start = start_r[0];
  assign if1.start = start_r[1];
  assign if2.start = start_r[2];
  assign if0.abort = abort_r[0];
  assign if1.abort = abort_r[1];
  assign if2.abort = abort_r[2];

  // Checker models. u0: combinational verdict on the live vector.
  // u1: always fails when fail1_all. u2: verdict on the vector from two cycles back.
  logic       mode0;
  logic       fail1_all;
  logic [1:0] mode2;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  always @(posedge clk) begin
    d1 <= if2.vec_out;
    d2 <= d1;
  end
  assign if0.spec_ok = !(mode0 && (if0.vec_out == 8'd3 || if0.vec_out == 8'd10 ||
                                   if0.vec_out == 8'd50));
  assign if1.spec_ok = !fail1_all;
  assign if2.spec_ok = !((mode2 == 2'd1 && (d2 == 8'h1A || d2 == 8'hC3)) ||
                         (mode2 == 2'd2 && d2 == 8'h05));

  logic [7:0] vo [3];
  logic [8:0] fc [3];
  logic [7:0] ff [3];
  logic       vv [3], bz [3], dn [3], ps [3];
  assign vo[0] = if0.vec_out;    assign vo[1] = if1.vec_out;    assign vo[2] = if2.vec_out;
  assign fc[0] = if0.fail_cnt;   assign fc[1] = if1.fail_cnt;   assign fc[2] = if2.fail_cnt;
  assign ff[0] = if0.first_fail; assign ff[1] = if1.first_fail; assign ff[2] = if2.first_fail;
  assign vv[0] = if0.vec_valid;  assign vv[1] = if1.vec_valid;  assign vv[2] = if2.vec_valid;
  assign bz[0] = if0.busy;       assign bz[1] = if1.busy;       assign bz[2] = if2.busy;
  assign dn[0] = if0.done;       assign dn[1] = if1.done;       assign dn[2] = if2.done;
  assign ps[0] = if0.pass;       assign ps[1] = if1.pass;       assign ps[2] = if2.pass;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input int idx, input string pfx);
    check_val($sformatf("%s_vec", pfx),   32'(vo[idx]), 32'h0);
    check_val($sformatf("%s_vld", pfx),   32'(vv[idx]), 32'h0);
    check_val($sformatf("%s_busy", pfx),  32'(bz[idx]), 32'h0);
    check_val($sformatf("%s_done", pfx),  32'(dn[idx]), 32'h0);
    check_val($sformatf("%s_pass", pfx),  32'(ps[idx]), 32'h0);
    check_val($sformatf("%s_fcnt", pfx),  32'(fc[idx]), 32'h0);
    check_val($sformatf("%s_first", pfx), 32'(ff[idx]), 32'h0);
  endtask

  // Pulses start for one edge; returns at the negedge of cycle start+1.
  task automatic pulse_start(input int idx);
    @(negedge clk);
    start_r[idx] = 1'b1;
    @(negedge clk);
    start_r[idx] = 1'b0;
  endtask

  // Observes cycles k=1.. (k=1 is the current negedge) until done or limit.
  task automatic sweep_watch(input int idx, input int abort_k, input int start_k,
                             input int limit, output int done_k, output int nvalid,
                             output int lastv, output int bad);
    done_k = -1; nvalid = 0; lastv = -1; bad = 0;
    for (int k = 1; k <= limit; k++) begin
      if (k > 1) @(negedge clk);
      start_r[idx] = (k == start_k);
      abort_r[idx] = (k == abort_k);
      if (vv[idx]) begin
        nvalid++;
        lastv = int'(vo[idx]);
        if (int'(vo[idx]) != k - 1) bad++;
      end
      if (dn[idx]) begin
        done_k = k;
        break;
      end
    end
    start_r[idx] = 1'b0;
    abort_r[idx] = 1'b0;
  endtask

  int dk, nv, lv, bd;

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      abort_r[i] = 1'b0;
    end
    mode0 = 1'b0; fail1_all = 1'b0; mode2 = 2'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals(0, "rst0");
    check_val("rst2_vld", 32'(vv[2]), 32'h0);
    rst = 1'b0;
    @(negedge clk);

`ifndef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    // LAT=0 clean sweep, with a stray start while busy.
    pulse_start(0);
    check_val("a_busy", 32'(bz[0]), 32'h1);
    sweep_watch(0, 0, 10, 400, dk, nv, lv, bd);
    check_val("a_done_k", 32'(dk), 32'd257);
    check_val("a_nvalid", 32'(nv), 32'd256);
    check_val("a_last",   32'(lv), 32'd255);
    check_val("a_steps",  32'(bd), 32'd0);
    check_val("a_pass",   32'(ps[0]), 32'h1);
    check_val("a_fcnt",   32'(fc[0]), 32'h0);
    @(negedge clk);
    check_val("a_done_pulse", 32'(dn[0]), 32'h0);
    check_val("a_idle_busy",  32'(bz[0]), 32'h0);
    check_val("a_pass_hold",  32'(ps[0]), 32'h1);

    // abort and start together in IDLE: abort wins.
    start_r[0] = 1'b1; abort_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0; abort_r[0] = 1'b0;
    check_val("as_busy", 32'(bz[0]), 32'h0);
    check_val("as_vld",  32'(vv[0]), 32'h0);
    check_val("as_pass", 32'(ps[0]), 32'h1);

    // Abort at vector 40 with failures at 3, 10, 50.
    mode0 = 1'b1;
    pulse_start(0);
    sweep_watch(0, 41, 0, 80, dk, nv, lv, bd);
    check_val("b_no_done", 32'(dk), 32'hFFFF_FFFF);
    check_val("b_nvalid",  32'(nv), 32'd41);
    check_val("b_last",    32'(lv), 32'd40);
    check_val("b_busy",    32'(bz[0]), 32'h0);
    check_val("b_fcnt",    32'(fc[0]), 32'd2);
    check_val("b_first",   32'(ff[0]), 32'd3);
    check_val("b_pass",    32'(ps[0]), 32'h0);
    pulse_start(0);
    check_val("b2_clr", 32'(fc[0]), 32'd0);
    sweep_watch(0, 0, 0, 400, dk, nv, lv, bd);
    check_val("b2_done_k", 32'(dk), 32'd257);
    check_val("b2_fcnt",   32'(fc[0]), 32'd3);
    check_val("b2_first",  32'(ff[0]), 32'd3);
    check_val("b2_pass",   32'(ps[0]), 32'h0);

    // LAT=1, every verdict fails: count reaches 256 without wrapping.
    fail1_all = 1'b1;
    pulse_start(1);
    sweep_watch(1, 0, 0, 400, dk, nv, lv, bd);
    check_val("c_done_k", 32'(dk), 32'd258);
    check_val("c_steps",  32'(bd), 32'd0);
    check_val("c_fcnt",   32'(fc[1]), 32'h100);
    check_val("c_first",  32'(ff[1]), 32'h0);
    check_val("c_pass",   32'(ps[1]), 32'h0);

    // LAT=2, failures at 1A and C3.
    mode2 = 2'd1;
    pulse_start(2);
    sweep_watch(2, 0, 0, 400, dk, nv, lv, bd);
    check_val("d_done_k", 32'(dk), 32'd259);
    check_val("d_nvalid", 32'(nv), 32'd256);
    check_val("d_fcnt",   32'(fc[2]), 32'd2);
    check_val("d_first",  32'(ff[2]), 32'h1A);
    check_val("d_pass",   32'(ps[2]), 32'h0);

    // LAT=2, single failure at 05: full sweep still runs.
    mode2 = 2'd2;
    pulse_start(2);
    sweep_watch(2, 0, 0, 400, dk, nv, lv, bd);
    check_val("e_done_k", 32'(dk), 32'd259);
    check_val("e_fcnt",   32'(fc[2]), 32'd1);
    check_val("e_first",  32'(ff[2]), 32'h05);

    // Asynchronous reset in the first DRAIN cycle.
    mode2 = 2'd1;
    pulse_start(2);
    sweep_watch(2, 0, 0, 257, dk, nv, lv, bd);
    check_val("f_in_drain", 32'(bz[2]), 32'h1);
    check_val("f_vld",      32'(vv[2]), 32'h0);
    check_val("f_fcnt",     32'(fc[2]), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_reset_vals(2, "f_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("f_no_done", 32'(dn[2]), 32'h0);
`else
    // LAT=2, stop at the first failure (vector 05).
    mode2 = 2'd2;
    pulse_start(2);
    sweep_watch(2, 0, 0, 400, dk, nv, lv, bd);
    check_val("s_done_k", 32'(dk), 32'd11);
    check_val("s_nvalid", 32'(nv), 32'd8);
    check_val("s_last",   32'(lv), 32'd7);
    check_val("s_fcnt",   32'(fc[2]), 32'd1);
    check_val("s_first",  32'(ff[2]), 32'h05);
    check_val("s_pass",   32'(ps[2]), 32'h0);

    // LAT=1, always failing: the in-flight vector 1 is still counted.
    fail1_all = 1'b1;
    pulse_start(1);
    sweep_watch(1, 0, 0, 400, dk, nv, lv, bd);
    check_val("s1_done_k", 32'(dk), 32'd4);
    check_val("s1_last",   32'(lv), 32'd1);
    check_val("s1_fcnt",   32'(fc[1]), 32'd2);
    check_val("s1_first",  32'(ff[1]), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
